audio_dither: RTL and testbench
===============================

# audio_dither

Single-clock audio conditioning stage between the audio clock-domain crossing and the FM modulator. It takes full-width signed samples from the I2S path, already synchronised into `clk`. It adds scalable TPDF dither, rounds, saturates and truncates each sample to the modulator's A-bit width, and emits each result with a one-cycle valid strobe. A compile-time timeout mute forces silence when the audio source stops.

## Interface
- `DW`, 16, input sample width; signed two's complement.
- `A`, 8, output sample width; `DW-A` must be in 1..8.
- `TIMEOUT_W`, 20, mute-timeout counter width; terminal count is 2^TIMEOUT_W-1 cycles.

- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `din`  input  DW  signed audio sample.
- `din_valid`  input  1  one-cycle strobe; `din` is valid in that cycle.
- `dith_fact`  input  3  dither scale; 0 = off, 7 = full TPDF of ±1 output LSB.
- `dout`  output  A  signed audio to the FM modulator.
- `dout_valid`  output  1  one-cycle strobe marking a new `dout`.
- `muted`  output  1  high while the timeout mute is active.

## Operation
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1. Advances every cycle regardless of `din_valid`.
- **Noise:** u1 = lfsr[DW-A-1:0], u2 = lfsr[2(DW-A)-1:DW-A], both unsigned. n = u1 − u2, giving a range of ±(2^(DW-A)−1). n is arithmetically right-shifted by (7 − `dith_fact`). For `dith_fact`=0, n is forced to 0, not shifted.
- **Stage 1:** updates only when `din_valid`=1. Computes s = sext(`din`) + n + 2^(DW-A-1) at width DW+2. `dith_fact` is sampled in the same cycle.
- **Stage 2:**
  - If s > 2^(DW-1)−1, `dout` = 2^(A-1)−1.
  - If s < −2^(DW-1), `dout` = −2^(A-1).
  - Otherwise `dout` = s[DW-1:DW-A].
  - `dout_valid` pulses for 1 cycle.
- `dout` holds its value between strobes.
- Back-to-back `din_valid` on every cycle is supported at full throughput; no back-pressure.

## Timing
- Latency: `din_valid` in cycle t gives `dout`/`dout_valid` in cycle t+2.
- **Reset values:**
  - `dout` = 0, `dout_valid` = 0, LFSR = seed, pipeline valid bits = 0.
  - Mute counter = 0.
  - `muted` = 1 with the mute feature compiled in, 0 without it.
- Reset asserted mid-pipeline discards in-flight samples. No `dout_valid` is produced for them.
- `dith_fact` changes take effect on the next `din_valid`. Samples already in flight keep the old value.
- Saturation is symmetric in rule but asymmetric in range: +max is 2^(A-1)−1 and −max is −2^(A-1).

## Configuration
- Macro: `AUDIO_DITHER_MUTE_EN`.
- **Defined:**
  - The counter increments each cycle without `din_valid` and saturates at terminal count; `din_valid` clears it to 0.
  - On reaching terminal count, `muted` goes to 1 and `dout` is forced to 0 in the same cycle.
  - While muted, `dout_valid` stays 0 except for real samples.
  - `muted` returns to 0 in the cycle of the first new `dout_valid`.
- **Undefined:** no counter is built, `muted` is tied to 0, and `dout` holds its last sample indefinitely.

## Structure
- Shared package `fm_tx_pkg` holds:
  - LFSR polynomial and seed constants;
  - the `dith_fact` type (3-bit);
  - the default `TIMEOUT_W`.
- One sub-module, `lfsr16`: Galois LFSR with `clk`, `rst_n` and 16-bit state output.
- The pipeline and mute logic stay in `audio_dither`.

## Test plan
All scenarios use defaults DW=16 and A=8 unless stated.
1. **Rounding:** `dith_fact`=0, `din`=16'h1280 strobed -> `dout`=8'h13, `dout_valid` high exactly 2 cycles after the strobe, then low.
2. **Saturation:** `dith_fact`=0.
   - `din`=16'h7FC0 -> `dout`=8'h7F.
   - `din`=16'h8000 -> `dout`=8'h80.
   - `din`=16'hFF7F -> `dout`=8'hFF.
3. **Dither bounds:** `dith_fact`=7, 1000 strobes of 16'h1280 -> every `dout` ∈ {8'h12, 8'h13}, both values present, count of 8'h13 within 50±5 %. With `dith_fact`=0, all 1000 are 8'h13.
4. **Throughput:** `din_valid` held high for 16 cycles with ramp `din`=k<<8, `dith_fact`=0 -> 16 consecutive `dout_valid` cycles, `dout`=k in order.
5. **Mute** (TIMEOUT_W=4, macro defined):
   - After reset, `muted`=1.
   - A sample arrives -> `muted` falls with its `dout_valid`.
   - No strobes for 15 cycles -> `muted`=1 and `dout`=0.
   - With the macro undefined, `muted` stays 0 and `dout` holds its value.
6. **Reset mid-operation:** assert `rst_n`=0 one cycle after a strobe -> no `dout_valid` appears, `dout`=0. The LFSR restarts at 16'hACE1, so the post-reset `dout` sequence repeats the post-power-up sequence.

Source files
------------

// File: rtl/fm_tx_pkg.sv
// Shared constants and types for the FM transmitter audio path.
package fm_tx_pkg;

    // x^16 + x^14 + x^13 + x^11 + 1 as right-shifting Galois feedback taps
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam int unsigned TIMEOUT_W_DEFAULT = 20;

    typedef logic [2:0] dith_fact_t;

endpackage

// File: rtl/audio_dither_lfsr16.sv
// 16-bit Galois LFSR, free-running from the shared seed; source of the dither noise.
module lfsr16
    import fm_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/audio_dither.sv
// TPDF dither, round, saturate and truncate DW-bit audio to A bits (2-cycle latency).
// Optional silence-timeout mute is compiled in with `define AUDIO_DITHER_MUTE_EN.
module audio_dither
    import fm_tx_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned A         = 8,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic [2:0]    dith_fact,
    output logic [A-1:0]  dout,
    output logic          dout_valid,
    output logic          muted
);

    localparam int unsigned D = DW - A;
    localparam logic [DW+1:0] ROUND = (DW + 2)'(1) << (D - 1);

    logic [15:0]       lfsr;
    dith_fact_t        fact;
    logic signed [D:0] noise_raw;
    logic signed [D:0] noise;
    logic [DW+1:0]     sum;
    logic [DW+1:0]     s1;
    logic              s1_valid;
    logic [A-1:0]      sat;
    logic              mute_hit;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    // if/else keeps the shift arithmetic; a ternary with '0 would make it unsigned
    always_comb begin
        fact      = dith_fact;
        noise_raw = $signed({1'b0, lfsr[D-1:0]}) - $signed({1'b0, lfsr[2*D-1:D]});
        if (fact == 3'd0) begin
            noise = '0;
        end else begin
            noise = noise_raw >>> (~fact);
        end
        sum = {{2{din[DW-1]}}, din} + {{(DW + 1 - D){noise[D]}}, noise} + ROUND;
    end

    // in range exactly when the top three bits of s agree
    always_comb begin
        if (!s1[DW+1] && (s1[DW:DW-1] != 2'b00)) begin
            sat = {1'b0, {(A - 1){1'b1}}};
        end else if (s1[DW+1] && (s1[DW:DW-1] != 2'b11)) begin
            sat = {1'b1, {(A - 1){1'b0}}};
        end else begin
            sat = s1[DW-1:DW-A];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s1_valid   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            s1_valid   <= din_valid;
            dout_valid <= s1_valid;
            if (din_valid) begin
                s1 <= sum;
            end
            if (s1_valid) begin
                dout <= sat;
            end else if (mute_hit) begin
                dout <= '0;
            end
        end
    end

`ifdef AUDIO_DITHER_MUTE_EN
    localparam logic [TIMEOUT_W-1:0] TERM = '1;

    logic [TIMEOUT_W-1:0] idle_cnt;
    logic                 muted_q;

    assign mute_hit = !din_valid && (idle_cnt >= TERM - 1'b1);
    assign muted    = muted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            muted_q  <= 1'b1;
        end else begin
            if (din_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TERM) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (s1_valid) begin
                muted_q <= 1'b0;
            end else if (mute_hit) begin
                muted_q <= 1'b1;
            end
        end
    end
`else
    assign mute_hit = 1'b0;
    // constant 0: TIMEOUT_W is always at least 1
    assign muted    = (TIMEOUT_W == 0);
`endif

endmodule

// File: tb/tb_audio_dither.sv
// Self-checking bench for audio_dither: vector table, hand sequences and a random run
// scored against an arithmetic reference model.
module tb_audio_dither;

    localparam int DW = 16;
    localparam int A  = 8;
    localparam int D  = DW - A;
    localparam int TW = 4;
`ifdef AUDIO_DITHER_MUTE_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif
    // feedback taps derived from the exponents 16, 14, 13, 11 of the polynomial
    localparam logic [15:0] TAPS = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [2:0]    dith_fact = 3'd0;
    logic [A-1:0]  dout;
    logic          dout_valid;
    logic          muted;

    audio_dither #(.DW(DW), .A(A), .TIMEOUT_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .dith_fact  (dith_fact),
        .dout       (dout),
        .dout_valid (dout_valid),
        .muted      (muted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [A-1:0] ref_dout(input logic [DW-1:0] d, input logic [2:0] f,
                                              input logic [15:0] l);
        int u1, u2, n, s, q;
        u1 = int'(l) % (1 << D);
        u2 = (int'(l) >> D) % (1 << D);
        n  = u1 - u2;
        if (f == 3'd0) n = 0;
        else n = floor_div(n, 1 << (7 - int'(f)));
        s = int'($signed(d)) + n + (1 << (D - 1));
        if (s > (1 << (DW - 1)) - 1) q = (1 << (A - 1)) - 1;
        else if (s < -(1 << (DW - 1))) q = -(1 << (A - 1));
        else q = floor_div(s, 1 << D);
        return A'(q);
    endfunction

    typedef struct {
        logic [A-1:0] val;
        int           due;
    } exp_t;

    exp_t         exp_q[$];
    logic [A-1:0] pred_log[$];
    logic [15:0]  m_lfsr = SEED;
    int           cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            m_lfsr = SEED;
            exp_q.delete();
        end else begin
            if (din_valid) begin
                e.val = ref_dout(din, dith_fact, m_lfsr);
                e.due = cyc + 2;
                exp_q.push_back(e);
                pred_log.push_back(e.val);
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
        cyc++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                fail_now("missing_valid", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", cyc, e.due);
                    check("model_dout", int'(dout), int'(e.val));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [DW-1:0] din;
        logic [A-1:0]  dout;
    } vec_t;

    vec_t          vecs[11];
    logic [DW-1:0] seq_din[8];
    logic [A-1:0]  got[8];
    logic [A-1:0]  pred1[8];

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_seq();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("seq_premute", int'(muted), int'(MUTE_EN));
                check("seq_novalid", int'(dout_valid), 0);
            end
            if (i == 2) check("seq_mute_release", int'(muted), 0);
            if (i >= 2 && i < 10) begin
                check("seq_valid", int'(dout_valid), 1);
                got[i-2] = dout;
            end
            din       = seq_din[i % 8];
            dith_fact = 3'd7;
            din_valid = (i < 8);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n12, n13, nbad;

        vecs[0]  = '{16'h1280, 8'h13};
        vecs[1]  = '{16'h7FC0, 8'h7F};
        vecs[2]  = '{16'h8000, 8'h80};
        vecs[3]  = '{16'hFF7F, 8'hFF};
        vecs[4]  = '{16'h0000, 8'h00};
        vecs[5]  = '{16'h007F, 8'h00};
        vecs[6]  = '{16'h0080, 8'h01};
        vecs[7]  = '{16'h7F7F, 8'h7F};
        vecs[8]  = '{16'h7F80, 8'h7F};
        vecs[9]  = '{16'hFF80, 8'h00};
        vecs[10] = '{16'h8080, 8'h81};
        seq_din  = '{16'h1280, 16'h0000, 16'h7FF0, 16'h8010,
                     16'hC3A5, 16'h0101, 16'h5A5A, 16'hFFFF};

        // reset state
        @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_muted", int'(muted), int'(MUTE_EN));

        // post-power-up dithered sequence
        release_reset();
        start = pred_log.size();
        run_seq();
        for (int i = 0; i < 8; i++) pred1[i] = pred_log[start + i];

        // vector table, dither off
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            din = vecs[v].din; dith_fact = 3'd0; din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            check("vec_early", int'(dout_valid), 0);
            @(negedge clk);
            check("vec_valid", int'(dout_valid), 1);
            check("vec_dout", int'(dout), int'(vecs[v].dout));
            @(negedge clk);
            check("vec_pulse", int'(dout_valid), 0);
            check("vec_hold", int'(dout), int'(vecs[v].dout));
        end

        // full-throughput ramp
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (i >= 2 && i < 18) begin
                check("ramp_valid", int'(dout_valid), 1);
                check("ramp_dout", int'(dout), i - 2);
            end
            if (i == 18) check("ramp_end", int'(dout_valid), 0);
            din = DW'((i % 16) << 8); dith_fact = 3'd0; din_valid = (i < 16);
        end

        // dither bounds: full scale, then off
        for (int f = 0; f < 2; f++) begin
            n12 = 0; n13 = 0; nbad = 0;
            for (int i = 0; i < 1002; i++) begin
                @(negedge clk);
                if (dout_valid) begin
                    if (dout == 8'h12) n12++;
                    else if (dout == 8'h13) n13++;
                    else nbad++;
                end
                din = 16'h1280; dith_fact = (f == 0) ? 3'd7 : 3'd0; din_valid = (i < 1000);
            end
            check("dith_out_of_set", nbad, 0);
            if (f == 0) begin
                check("dith_has_12", int'(n12 > 0), 1);
                check("dith_has_13", int'(n13 > 0), 1);
                check("dith_balance", int'(n13 >= 450 && n13 <= 550), 1);
            end else begin
                check("nodith_all_13", n13, 1000);
            end
        end

        // random samples, gaps and dither factors
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            din_valid = ($urandom_range(0, 3) != 0);
            dith_fact = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: din = 16'h7FFF;
                1: din = 16'h8000;
                2: din = 16'h7F80 + 16'($urandom_range(0, 255));
                default: din = 16'($urandom);
            endcase
        end
        din_valid = 1'b0;
        repeat (4) @(negedge clk);

        // silence timeout
        @(negedge clk);
        din = 16'h1280; dith_fact = 3'd0; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int j = 2; j <= 16; j++) begin
            @(negedge clk);
            if (j == 2) begin
                check("mute_sample", int'(dout), 8'h13);
                check("mute_cleared", int'(muted), 0);
            end
            if (j == 15) check("mute_not_yet", int'(muted), 0);
            if (j == 16) begin
                check("mute_set", int'(muted), int'(MUTE_EN));
                check("mute_dout", int'(dout), MUTE_EN ? 0 : 8'h13);
            end
        end
        repeat (10) @(negedge clk);
        check("mute_stays", int'(muted), int'(MUTE_EN));
        check("mute_dout_later", int'(dout), MUTE_EN ? 0 : 8'h13);

        // reset one cycle after a strobe
        @(negedge clk);
        din = 16'h4321; dith_fact = 3'd0; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("midrst_valid", int'(dout_valid), 0);
            check("midrst_dout", int'(dout), 0);
        end
        check("midrst_muted", int'(muted), int'(MUTE_EN));
        release_reset();
        run_seq();
        for (int i = 0; i < 8; i++) check("replay_dout", int'(got[i]), int'(pred1[i]));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
